apb_machine_timer: RTL and testbench



---
 rtl/apb_machine_timer.sv | 126 ++++++++++++
 tb/tb_apb_machine_timer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/apb_machine_timer.sv
// RISC-V style machine timer behind a zero-wait-state APB3 completer.
// Free-running 64-bit mtime with prescaler, 64-bit mtimecmp and a level interrupt.
module apb_machine_timer #(
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 psel_i,
   input  logic                 penable_i,
   input  logic                 pwrite_i,
   input  logic [AddrWidth-1:0] paddr_i,
   input  logic [DataWidth-1:0] pwdata_i,
   output logic [DataWidth-1:0] prdata_o,
   output logic                 pready_o,
   output logic                 pslverr_o,
   output logic                 timer_irq_o
);

   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        en_q, en_d;
   logic [7:0]  presc_q, presc_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        irq_q, irq_d;

   logic [4:0]  offset;
   logic        access, addr_err, wr_en, rd_en, tick;
   logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
   logic        unused_paddr;

   // Only the window offset is decoded; the upper address bits are the demux's business.
   assign unused_paddr = ^paddr_i[AddrWidth-1:5];

   assign offset    = paddr_i[4:0];
   assign access    = psel_i & penable_i;
   assign addr_err  = (offset > 5'h10) | (offset[1:0] != 2'b00);
   assign wr_en     = access & pwrite_i & ~addr_err;
   assign rd_en     = access & ~pwrite_i & ~addr_err;
   assign pslverr_o = access & addr_err;
   assign pready_o  = 1'b1;

   assign wr_mtime_lo = wr_en & (offset == 5'h00);
   assign wr_mtime_hi = wr_en & (offset == 5'h04);
   assign wr_cmp_lo   = wr_en & (offset == 5'h08);
   assign wr_cmp_hi   = wr_en & (offset == 5'h0C);
   assign wr_ctrl     = wr_en & (offset == 5'h10);

   assign tick = en_q & (cnt_q == presc_q);

   always_comb begin
      cnt_d = cnt_q;
      if (en_q) begin
         cnt_d = tick ? 8'd0 : cnt_q + 8'd1;
      end
      if (wr_ctrl) begin
         cnt_d = 8'd0;
      end
   end

   // A software write to either half suppresses that cycle's tick for the whole counter.
   always_comb begin
      mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
      if (wr_mtime_lo) begin
         mtime_d = {mtime_q[63:32], pwdata_i};
      end else if (wr_mtime_hi) begin
         mtime_d = {pwdata_i, mtime_q[31:0]};
      end
   end

   always_comb begin
      mtimecmp_d = mtimecmp_q;
      if (wr_cmp_lo) begin
         mtimecmp_d[31:0] = pwdata_i;
      end
      if (wr_cmp_hi) begin
         mtimecmp_d[63:32] = pwdata_i;
      end
   end

   always_comb begin
      en_d    = en_q;
      presc_d = presc_q;
      if (wr_ctrl) begin
         en_d    = pwdata_i[0];
         presc_d = pwdata_i[15:8];
      end
   end

   assign irq_d = (mtime_q >= mtimecmp_q);

   always_comb begin
      prdata_o = '0;
      if (rd_en) begin
         unique case (offset[4:2])
            3'd0:    prdata_o = mtime_q[31:0];
            3'd1:    prdata_o = mtime_q[63:32];
            3'd2:    prdata_o = mtimecmp_q[31:0];
            3'd3:    prdata_o = mtimecmp_q[63:32];
            3'd4:    prdata_o = {16'h0000, presc_q, 7'h00, en_q};
            default: prdata_o = '0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mtime_q    <= 64'd0;
         mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
         en_q       <= 1'b1;
         presc_q    <= 8'd0;
         cnt_q      <= 8'd0;
         irq_q      <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         en_q       <= en_d;
         presc_q    <= presc_d;
         cnt_q      <= cnt_d;
         irq_q      <= irq_d;
      end
   end

   assign timer_irq_o = irq_q;

endmodule

// File: tb/tb_apb_machine_timer.sv
// Scoreboard bench for apb_machine_timer: each APB transfer queues its expected response,
// and a negedge monitor compares whenever an access phase is on the bus.
module tb_apb_machine_timer;

   localparam logic [31:0] MTL = 32'h00;
   localparam logic [31:0] MTH = 32'h04;
   localparam logic [31:0] CPL = 32'h08;
   localparam logic [31:0] CPH = 32'h0C;
   localparam logic [31:0] CTL = 32'h10;
   localparam logic [1:0]  DC  = 2'd2;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] mask;
      logic        err;
      logic [1:0]  irq;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata, prdata;
   logic        pready, pslverr, timer_irq;

   exp_t  sb[$];
   string names[$];
   int    vectors = 0;
   int    miscompares = 0;

   always #5 clk = ~clk;

   apb_machine_timer #(.AddrWidth(32), .DataWidth(32)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .psel_i     (psel),
      .penable_i  (penable),
      .pwrite_i   (pwrite),
      .paddr_i    (paddr),
      .pwdata_i   (pwdata),
      .prdata_o   (prdata),
      .pready_o   (pready),
      .pslverr_o  (pslverr),
      .timer_irq_o(timer_irq)
   );

   // Monitor: one scoreboard entry per access phase; idle cycles must keep the bus quiet.
   always @(negedge clk) begin
      exp_t  e;
      string nm;
      if (psel && penable) begin
         if (sb.size() == 0) begin
            $display("FAIL unexpected_access: no expected entry queued at %0t", $time);
            miscompares++;
         end else begin
            e  = sb.pop_front();
            nm = names.pop_front();
            vectors++;
            if (((prdata & e.mask) !== (e.data & e.mask)) || (pslverr !== e.err) ||
                (e.irq != DC && timer_irq !== e.irq[0])) begin
               $display("FAIL %s: got prdata=%h pslverr=%b irq=%b, want prdata=%h (mask %h) pslverr=%b irq=%0d",
                        nm, prdata, pslverr, timer_irq, e.data, e.mask, e.err, e.irq);
               miscompares++;
            end
         end
      end else if (prdata !== 32'h0 || pslverr !== 1'b0) begin
         $display("FAIL idle_bus: got prdata=%h pslverr=%b, want 0/0 at %0t", prdata, pslverr, $time);
         miscompares++;
      end
      if (pready !== 1'b1) begin
         $display("FAIL pready: got %b, want 1 at %0t", pready, $time);
         miscompares++;
      end
   end

   // Called one step after a rising edge; leaves the bus idle one step after the access edge.
   task automatic xfer(input string nm, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] ed, input logic [31:0] em,
                       input logic ee, input logic [1:0] ei);
      exp_t e;
      e.data = ed;
      e.mask = em;
      e.err  = ee;
      e.irq  = ei;
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wd;
      sb.push_back(e);
      names.push_back(nm);
      @(posedge clk);
      #1 penable = 1'b1;
      @(posedge clk);
      #1;
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] d);
      xfer($sformatf("wr_%h", addr[7:0]), 1'b1, addr, d, 32'h0, 32'hFFFF_FFFF, 1'b0, DC);
   endtask

   task automatic rd(input string nm, input logic [31:0] addr, input logic [31:0] d,
                     input logic [1:0] irq);
      xfer(nm, 1'b0, addr, 32'h0, d, 32'hFFFF_FFFF, 1'b0, irq);
   endtask

   task automatic err(input string nm, input logic w, input logic [31:0] addr,
                      input logic [31:0] d);
      xfer(nm, w, addr, d, 32'h0, 32'hFFFF_FFFF, 1'b1, DC);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset values (mtime low word is already counting)
      xfer("rst_mtime_lo", 1'b0, MTL, 32'h0, 32'h0, 32'h0, 1'b0, 2'd0);
      rd("rst_mtime_hi", MTH, 32'h0, 2'd0);
      rd("rst_cmp_lo", CPL, 32'hFFFF_FFFF, 2'd0);
      rd("rst_cmp_hi", CPH, 32'hFFFF_FFFF, 2'd0);
      rd("rst_ctrl", CTL, 32'h0000_0001, 2'd0);

      // Carry across halves: five ticks from FFFFFFFE
      wr(CTL, 32'h0); wr(MTL, 32'hFFFF_FFFE); wr(MTH, 32'h0); wr(CTL, 32'h1);
      idle(3);
      wr(CTL, 32'h0);
      rd("carry_hi", MTH, 32'h1, 2'd0);
      rd("carry_lo", MTL, 32'h3, 2'd0);

      // Interrupt timing against mtimecmp = 20
      wr(MTH, 32'h0); wr(MTL, 32'd19); wr(CPH, 32'h0); wr(CPL, 32'd20); wr(CTL, 32'h1);
      rd("irq_not_early", MTL, 32'd20, 2'd0);
      wr(CTL, 32'h0); wr(MTL, 32'd19); wr(CTL, 32'h1);
      idle(1);
      rd("irq_rise", MTL, 32'd21, 2'd1);
      wr(CPH, 32'hFFFF_FFFF);
      rd("irq_fall", MTL, 32'd25, 2'd0);

      // Prescaler of 3: ticks on the 4th, 8th, 12th edge after the CTRL write
      wr(CTL, 32'h0); wr(MTL, 32'h0); wr(MTH, 32'h0); wr(CTL, 32'h0000_0301);
      idle(2);
      rd("presc_p3", MTL, 32'd0, 2'd0);
      rd("presc_p5", MTL, 32'd1, 2'd0);
      rd("presc_p7", MTL, 32'd1, 2'd0);
      rd("presc_p9", MTL, 32'd2, 2'd0);
      wr(CTL, 32'h0);
      rd("ctrl_off", CTL, 32'h0, 2'd0);
      wr(CTL, 32'hFFFF_FF00);
      rd("ctrl_mask", CTL, 32'h0000_FF00, 2'd0);
      idle(50);
      rd("frozen", MTL, 32'd3, 2'd0);

      // 64-bit wrap, then a running write drops its tick and leaves the high half alone
      wr(MTH, 32'hFFFF_FFFF); wr(MTL, 32'hFFFF_FFFF); wr(CTL, 32'h1);
      rd("wrap_lo", MTL, 32'h0, 2'd1);
      rd("wrap_hi", MTH, 32'h0, 2'd0);
      wr(MTL, 32'd100);
      rd("wr_drop_tick", MTL, 32'd101, 2'd0);
      rd("wr_keep_hi", MTH, 32'h0, 2'd0);
      wr(CTL, 32'h0);

      // Error responses leave every register untouched
      err("err_wr_14", 1'b1, 32'h14, 32'hFFFF_FFFF);
      err("err_wr_02", 1'b1, 32'h02, 32'hFFFF_FFFF);
      err("err_wr_0a", 1'b1, 32'h0A, 32'h0);
      err("err_rd_14", 1'b0, 32'h14, 32'h0);
      err("err_rd_02", 1'b0, 32'h02, 32'h0);
      err("err_rd_0d", 1'b0, 32'h0D, 32'h0);
      rd("err_keep_mtime", MTL, 32'd106, 2'd0);
      rd("err_keep_ctrl", CTL, 32'h0, 2'd0);
      rd("err_keep_cmp_lo", 32'h4000_0008, 32'd20, 2'd0);
      rd("err_keep_cmp_hi", CPH, 32'hFFFF_FFFF, 2'd0);

      idle(2);
      if (sb.size() != 0) begin
         $display("FAIL drain: %0d expected responses never observed, want 0", sb.size());
         miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
